sram_way_ctrl: RTL and testbench
================================

Name: sram_way_ctrl

Overview:
- Controller sequencing one 256-set x 4-way x 20-bit two-port SRAM instance (8-bit address, 80-bit data, 4-bit way mask).
- Clears the array after reset and on flush.
- Round-robin arbitrates two write requesters (A: update, B: refill) onto the single write port.
- Gates the read port and forwards same-cycle write data to a colliding read, so read-during-write is deterministic.

Parameters:
- SETS, 256, number of sets; address width is log2(SETS) = 8.
- WAYS, 4, ways per set; one mask bit per way.
- WAYW, 20, bits per way; data width is WAYS*WAYW = 80.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- flush_req  in  1  request full re-clear.
- init_done  out  1  array cleared, controller accepting traffic.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted.
- rd_addr  in  8  read set.
- rd_resp_valid  out  1  read data valid.
- rd_resp_data  out  80  read data, way i at bits [20i+19:20i].
- wa_valid  in  1  write request A.
- wa_ready  out  1  A granted.
- wa_addr  in  8  A set.
- wa_data  in  80  A data.
- wa_mask  in  4  A way mask.
- wb_valid  in  1  write request B.
- wb_ready  out  1  B granted.
- wb_addr  in  8  B set.
- wb_data  in  80  B data.
- wb_mask  in  4  B way mask.
- sram_r_addr  out  8  to SRAM read address.
- sram_r_data  in  80  from SRAM; valid the cycle after sram_r_addr.
- sram_w_en  out  1  to SRAM write enable.
- sram_w_addr  out  8  to SRAM write address.
- sram_w_data  out  80  to SRAM write data.
- sram_w_mask  out  4  to SRAM write mask.

Behaviour:
- State machine: CLEAR, RUN. Reset (reset=0) forces:
  - CLEAR, clear pointer = 0, rr priority = A.
  - init_done = 0, rd_resp_valid = 0, rd_resp_data = 0, bypass register cleared.
- CLEAR:
  - Each cycle: sram_w_en=1, sram_w_addr=ptr, sram_w_data=0, sram_w_mask=4'hF; ptr increments.
  - After writing ptr=255: ptr wraps to 0, go to RUN.
  - First write occurs in the first cycle after reset release; 256 cycles total. init_done=1 from the first RUN cycle.
  - rd_ready=wa_ready=wb_ready=0. flush_req is ignored.
- RUN:
  - init_done=1, rd_ready=1.
  - Grant rule: wa_ready = wa_valid & (!wb_valid | prio==A); wb_ready = wb_valid & (!wa_valid | prio==B).
  - After any grant, prio points to the non-granted requester.
  - Granted request drives sram_w_* in the same cycle. With no grant, sram_w_en=0.
- flush_req=1 in RUN:
  - Grants and reads of that cycle complete normally.
  - CLEAR begins next cycle, ptr=0, init_done drops to 0 that cycle.
- Read path:
  - rd_valid & rd_ready at cycle t → sram_r_addr=rd_addr at t; rd_resp_valid=1 at t+1 for one cycle.
  - When rd_valid is low, sram_r_addr holds its last value.
- Bypass:
  - If a write is granted at t with w_addr == rd_addr, register the write data and mask.
  - At t+1, for each way i with mask[i]=1, rd_resp_data way i = written data. Other ways come from sram_r_data.
  - No bypass for writes at t+1 or later. A read at t returns pre-write contents for those.
- Reset asserted mid-CLEAR or mid-RUN: immediate return to reset state. Clearing restarts at set 0.
- Read issued in the flush cycle: response at t+1 is returned normally.

Optional Feature:
- SRAM_WAY_CTRL_PERF_EN defined:
  - Adds outputs perf_conflicts (16-bit): cycles in RUN with wa_valid & wb_valid.
  - Adds perf_bypass (16-bit): bypass hits.
  - Both saturate at 16'hFFFF and clear on reset only (not on flush).
- Macro undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Release reset → sram_w_en=1, mask 4'hF, data 0, addresses 0..255 on consecutive cycles; init_done=1 exactly 256 cycles after release; all readies 0 meanwhile.
- RUN: wa_valid and wb_valid held high 4 cycles → grants A,B,A,B; with only wb_valid held → B granted every cycle.
- Write A addr 0x10, data way2=0xABCDE, mask 4'b0100 at t, read 0x10 at t → rd_resp_data at t+1 way2=0xABCDE, other ways from sram_r_data; same read at t-1 → no forwarding.
- flush_req pulse with wa_valid=1 in same cycle → A write performed, next cycle CLEAR from set 0, init_done=0 for 256 cycles, flush_req during CLEAR has no effect.
- Assert reset at ptr=100 → outputs reset; after release clearing restarts at address 0.
- With SRAM_WAY_CTRL_PERF_EN: 5 contention cycles and 2 bypass hits → perf_conflicts=5, perf_bypass=2; force 70000 contention cycles → 16'hFFFF.

Source files
------------

// File: rtl/sram_way_ctrl.sv
// Sequencer for one SETS x WAYS x WAYW two-port SRAM: post-reset/flush clear, round-robin write
// arbitration, read gating and same-cycle write-to-read forwarding. Optional macro: SRAM_WAY_CTRL_PERF_EN.
module sram_way_ctrl #(
  parameter int unsigned SETS = 256,
  parameter int unsigned WAYS = 4,
  parameter int unsigned WAYW = 20
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush_req,
  output logic                      init_done,
  input  logic                      rd_valid,
  output logic                      rd_ready,
  input  logic [$clog2(SETS)-1:0]   rd_addr,
  output logic                      rd_resp_valid,
  output logic [WAYS*WAYW-1:0]      rd_resp_data,
  input  logic                      wa_valid,
  output logic                      wa_ready,
  input  logic [$clog2(SETS)-1:0]   wa_addr,
  input  logic [WAYS*WAYW-1:0]      wa_data,
  input  logic [WAYS-1:0]           wa_mask,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic [$clog2(SETS)-1:0]   wb_addr,
  input  logic [WAYS*WAYW-1:0]      wb_data,
  input  logic [WAYS-1:0]           wb_mask,
  output logic [$clog2(SETS)-1:0]   sram_r_addr,
  input  logic [WAYS*WAYW-1:0]      sram_r_data,
  output logic                      sram_w_en,
  output logic [$clog2(SETS)-1:0]   sram_w_addr,
  output logic [WAYS*WAYW-1:0]      sram_w_data,
  output logic [WAYS-1:0]           sram_w_mask
`ifdef SRAM_WAY_CTRL_PERF_EN
  ,
  output logic [15:0]               perf_conflicts,
  output logic [15:0]               perf_bypass
`endif
);

  localparam int unsigned AW = $clog2(SETS);
  localparam int unsigned DW = WAYS * WAYW;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]      r_state;
  logic [AW-1:0]   r_ptr;
  logic            r_prio;        // 0: A has priority, 1: B
  logic            r_resp_valid;
  logic [AW-1:0]   r_raddr;
  logic [WAYS-1:0] r_byp_mask;
  logic [DW-1:0]   r_byp_data;

  logic w_run;
  logic w_rd_acc;
  logic w_grant_a;
  logic w_grant_b;
  logic w_byp_hit;

  assign w_run     = (r_state == S_RUN);
  assign w_grant_a = w_run & wa_valid & (~wb_valid | ~r_prio);
  assign w_grant_b = w_run & wb_valid & (~wa_valid |  r_prio);
  assign w_rd_acc  = w_run & rd_valid;

  assign init_done     = w_run;
  assign rd_ready      = w_run;
  assign wa_ready      = w_grant_a;
  assign wb_ready      = w_grant_b;
  assign rd_resp_valid = r_resp_valid;
  assign sram_r_addr   = w_rd_acc ? rd_addr : r_raddr;

  always_comb begin
    sram_w_en   = 1'b0;
    sram_w_addr = '0;
    sram_w_data = '0;
    sram_w_mask = '0;
    if (!w_run) begin
      sram_w_en   = 1'b1;
      sram_w_addr = r_ptr;
      sram_w_mask = '1;
    end else if (w_grant_a) begin
      sram_w_en   = 1'b1;
      sram_w_addr = wa_addr;
      sram_w_data = wa_data;
      sram_w_mask = wa_mask;
    end else if (w_grant_b) begin
      sram_w_en   = 1'b1;
      sram_w_addr = wb_addr;
      sram_w_data = wb_data;
      sram_w_mask = wb_mask;
    end
  end

  // A write landing on the set being read this cycle overrides the stale SRAM ways next cycle
  assign w_byp_hit = w_rd_acc & (w_grant_a | w_grant_b) & (sram_w_addr == rd_addr);

  always_comb begin
    rd_resp_data = '0;
    if (r_resp_valid) begin
      for (int unsigned i = 0; i < WAYS; i++) begin
        rd_resp_data[i*WAYW +: WAYW] = r_byp_mask[i] ? r_byp_data[i*WAYW +: WAYW]
                                                     : sram_r_data[i*WAYW +: WAYW];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_CLEAR;
      r_ptr        <= '0;
      r_prio       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_raddr      <= '0;
      r_byp_mask   <= '0;
      r_byp_data   <= '0;
    end else begin
      r_resp_valid <= w_rd_acc;
      if (w_rd_acc) r_raddr <= rd_addr;
      r_byp_mask <= w_byp_hit ? sram_w_mask : '0;
      if (w_byp_hit) r_byp_data <= sram_w_data;
      if (w_grant_a)      r_prio <= 1'b1;
      else if (w_grant_b) r_prio <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          if (r_ptr == AW'(SETS - 1)) begin
            r_state <= S_RUN;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: begin
          if (flush_req) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
          end
        end
      endcase
    end
  end

`ifdef SRAM_WAY_CTRL_PERF_EN
  logic [15:0] r_perf_conf;
  logic [15:0] r_perf_byp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_conf <= '0;
      r_perf_byp  <= '0;
    end else begin
      if (w_run && wa_valid && wb_valid && (r_perf_conf != '1)) r_perf_conf <= r_perf_conf + 1'b1;
      if (w_byp_hit && (r_perf_byp != '1))                      r_perf_byp  <= r_perf_byp + 1'b1;
    end
  end

  assign perf_conflicts = r_perf_conf;
  assign perf_bypass    = r_perf_byp;
`endif

endmodule

// File: tb/tb_sram_way_ctrl.sv
// Directed bench for sram_way_ctrl: vector table for arbitration/read/forwarding plus clear, flush and reset sequences.
module tb_sram_way_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush_req;
  logic        init_done;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_addr;
  logic        rd_resp_valid;
  logic [79:0] rd_resp_data;
  logic        wa_valid;
  logic        wa_ready;
  logic [7:0]  wa_addr;
  logic [79:0] wa_data;
  logic [3:0]  wa_mask;
  logic        wb_valid;
  logic        wb_ready;
  logic [7:0]  wb_addr;
  logic [79:0] wb_data;
  logic [3:0]  wb_mask;
  logic [7:0]  sram_r_addr;
  logic [79:0] sram_r_data;
  logic        sram_w_en;
  logic [7:0]  sram_w_addr;
  logic [79:0] sram_w_data;
  logic [3:0]  sram_w_mask;
`ifdef SRAM_WAY_CTRL_PERF_EN
  logic [15:0] perf_conflicts;
  logic [15:0] perf_bypass;
`endif

  always #5 clock = ~clock;

  sram_way_ctrl #(.SETS(256), .WAYS(4), .WAYW(20)) dut (
    .clock(clock), .reset(reset), .flush_req(flush_req), .init_done(init_done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data(wa_data), .wa_mask(wa_mask),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data), .wb_mask(wb_mask),
    .sram_r_addr(sram_r_addr), .sram_r_data(sram_r_data),
    .sram_w_en(sram_w_en), .sram_w_addr(sram_w_addr), .sram_w_data(sram_w_data), .sram_w_mask(sram_w_mask)
`ifdef SRAM_WAY_CTRL_PERF_EN
    , .perf_conflicts(perf_conflicts), .perf_bypass(perf_bypass)
`endif
  );

  localparam logic [79:0] Z   = 80'h0;
  localparam logic [79:0] P   = 80'h11111_22222_33333_44444;
  localparam logic [79:0] Q   = 80'h55555_66666_77777_88888;
  localparam logic [79:0] DA  = 80'h0A0A0_0B0B0_0C0C0_0D0D0;
  localparam logic [79:0] DB  = 80'h1B1B1_2B2B2_3B3B3_4B4B4;
  localparam logic [79:0] BY  = 80'h00000_ABCDE_00000_00000;
  localparam logic [79:0] FF  = 80'hFFFFF_FFFFF_FFFFF_FFFFF;
  localparam logic [79:0] DB2 = 80'h99999_12345_67890_AAAAA;
  localparam logic [79:0] R8  = 80'h11111_ABCDE_33333_44444;
  localparam logic [79:0] R11 = 80'h99999_66666_77777_AAAAA;

  typedef struct {
    logic rdv; logic [7:0] rda;
    logic wav; logic [7:0] waa; logic [79:0] wad; logic [3:0] wam;
    logic wbv; logic [7:0] wba; logic [79:0] wbd; logic [3:0] wbm;
    logic [79:0] srd;
    logic e_wen; logic [7:0] e_waddr; logic [79:0] e_wdata; logic [3:0] e_wmask;
    logic e_ar; logic e_br; logic [7:0] e_raddr; logic e_rv; logic [79:0] e_rd;
  } vec_t;

  localparam int NV = 14;
  vec_t v[NV];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    flush_req = 1'b0; rd_valid = 1'b0; rd_addr = 8'h00;
    wa_valid = 1'b0; wa_addr = 8'h00; wa_data = Z; wa_mask = 4'h0;
    wb_valid = 1'b0; wb_addr = 8'h00; wb_data = Z; wb_mask = 4'h0;
    sram_r_data = P;
  endtask

  // Checks n clear cycles starting at set 'start' with all requesters active; flush pulsed at cycle flush_at.
  task automatic clear_check(input int unsigned n, input int unsigned start, input int unsigned flush_at);
    for (int unsigned i = 0; i < n; i++) begin
      rd_valid = 1'b1; wa_valid = 1'b1; wb_valid = 1'b1;
      flush_req = (i == flush_at);
      #1;
      chk("clr_wen",   80'(sram_w_en),   80'd1);
      chk("clr_waddr", 80'(sram_w_addr), 80'(start + i));
      chk("clr_wdata", sram_w_data,      Z);
      chk("clr_wmask", 80'(sram_w_mask), 80'hF);
      chk("clr_rdy",   80'({rd_ready, wa_ready, wb_ready}), 80'd0);
      chk("clr_init",  80'(init_done),   80'd0);
      @(posedge clock); #1;
    end
    idle();
  endtask

  initial begin
    v[0]  = '{1'b1, 8'h07, 1'b1, 8'h01, DA, 4'hF, 1'b1, 8'h02, DB, 4'h3, Z,
              1'b1, 8'h01, DA, 4'hF, 1'b1, 1'b0, 8'h07, 1'b0, Z};
    v[1]  = '{1'b0, 8'h00, 1'b1, 8'h01, DA, 4'hF, 1'b1, 8'h02, DB, 4'h3, P,
              1'b1, 8'h02, DB, 4'h3, 1'b0, 1'b1, 8'h07, 1'b1, P};
    v[2]  = '{1'b0, 8'h00, 1'b1, 8'h01, DA, 4'hF, 1'b1, 8'h02, DB, 4'h3, P,
              1'b1, 8'h01, DA, 4'hF, 1'b1, 1'b0, 8'h07, 1'b0, Z};
    v[3]  = '{1'b0, 8'h00, 1'b1, 8'h01, DA, 4'hF, 1'b1, 8'h02, DB, 4'h3, P,
              1'b1, 8'h02, DB, 4'h3, 1'b0, 1'b1, 8'h07, 1'b0, Z};
    v[4]  = '{1'b0, 8'h00, 1'b0, 8'h01, DA, 4'hF, 1'b1, 8'h02, DB, 4'h3, P,
              1'b1, 8'h02, DB, 4'h3, 1'b0, 1'b1, 8'h07, 1'b0, Z};
    v[5]  = v[4];
    v[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, Z, 4'h0, 1'b0, 8'h00, Z, 4'h0, P,
              1'b0, 8'h00, Z, 4'h0, 1'b0, 1'b0, 8'h07, 1'b0, Z};
    v[7]  = '{1'b1, 8'h10, 1'b1, 8'h10, BY, 4'h4, 1'b0, 8'h00, Z, 4'h0, Z,
              1'b1, 8'h10, BY, 4'h4, 1'b1, 1'b0, 8'h10, 1'b0, Z};
    v[8]  = '{1'b1, 8'h10, 1'b0, 8'h00, Z, 4'h0, 1'b0, 8'h00, Z, 4'h0, P,
              1'b0, 8'h00, Z, 4'h0, 1'b0, 1'b0, 8'h10, 1'b1, R8};
    v[9]  = '{1'b0, 8'h00, 1'b1, 8'h10, FF, 4'hF, 1'b0, 8'h00, Z, 4'h0, P,
              1'b1, 8'h10, FF, 4'hF, 1'b1, 1'b0, 8'h10, 1'b1, P};
    v[10] = '{1'b1, 8'h33, 1'b1, 8'h44, DA, 4'hF, 1'b1, 8'h33, DB2, 4'h9, Z,
              1'b1, 8'h33, DB2, 4'h9, 1'b0, 1'b1, 8'h33, 1'b0, Z};
    v[11] = '{1'b1, 8'h40, 1'b1, 8'h41, DA, 4'hF, 1'b0, 8'h00, Z, 4'h0, Q,
              1'b1, 8'h41, DA, 4'hF, 1'b1, 1'b0, 8'h40, 1'b1, R11};
    v[12] = '{1'b0, 8'h00, 1'b0, 8'h00, Z, 4'h0, 1'b0, 8'h00, Z, 4'h0, Q,
              1'b0, 8'h00, Z, 4'h0, 1'b0, 1'b0, 8'h40, 1'b1, Q};
    v[13] = '{1'b0, 8'h00, 1'b0, 8'h00, Z, 4'h0, 1'b0, 8'h00, Z, 4'h0, P,
              1'b0, 8'h00, Z, 4'h0, 1'b0, 1'b0, 8'h40, 1'b0, Z};

    reset = 1'b0;
    idle();
    rd_valid = 1'b1; wa_valid = 1'b1; wb_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_init",   80'(init_done),     80'd0);
    chk("rst_rvalid", 80'(rd_resp_valid), 80'd0);
    chk("rst_rdata",  rd_resp_data,       Z);
    chk("rst_rdy",    80'({rd_ready, wa_ready, wb_ready}), 80'd0);

    @(negedge clock); reset = 1'b1; #1;
    clear_check(256, 0, 50);
    chk("init_after_clear", 80'(init_done), 80'd1);

    for (int i = 0; i < NV; i++) begin
      rd_valid = v[i].rdv; rd_addr = v[i].rda;
      wa_valid = v[i].wav; wa_addr = v[i].waa; wa_data = v[i].wad; wa_mask = v[i].wam;
      wb_valid = v[i].wbv; wb_addr = v[i].wba; wb_data = v[i].wbd; wb_mask = v[i].wbm;
      sram_r_data = v[i].srd;
      #1;
      chk($sformatf("v%0d_wen", i), 80'(sram_w_en), 80'(v[i].e_wen));
      if (v[i].e_wen) begin
        chk($sformatf("v%0d_waddr", i), 80'(sram_w_addr), 80'(v[i].e_waddr));
        chk($sformatf("v%0d_wdata", i), sram_w_data,      v[i].e_wdata);
        chk($sformatf("v%0d_wmask", i), 80'(sram_w_mask), 80'(v[i].e_wmask));
      end
      chk($sformatf("v%0d_wa_ready", i), 80'(wa_ready),      80'(v[i].e_ar));
      chk($sformatf("v%0d_wb_ready", i), 80'(wb_ready),      80'(v[i].e_br));
      chk($sformatf("v%0d_run", i),      80'({init_done, rd_ready}), 80'd3);
      chk($sformatf("v%0d_raddr", i),    80'(sram_r_addr),   80'(v[i].e_raddr));
      chk($sformatf("v%0d_rvalid", i),   80'(rd_resp_valid), 80'(v[i].e_rv));
      chk($sformatf("v%0d_rdata", i),    rd_resp_data,       v[i].e_rd);
      @(posedge clock); #1;
    end
    idle();

`ifdef SRAM_WAY_CTRL_PERF_EN
    chk("perf_conflicts", 80'(perf_conflicts), 80'd5);
    chk("perf_bypass",    80'(perf_bypass),    80'd2);
`endif

    // flush with a concurrent A write and read
    flush_req = 1'b1; wa_valid = 1'b1; wa_addr = 8'h20; wa_data = DA; wa_mask = 4'hF;
    rd_valid = 1'b1; rd_addr = 8'h05;
    #1;
    chk("flush_wa_ready", 80'(wa_ready),    80'd1);
    chk("flush_wen",      80'(sram_w_en),   80'd1);
    chk("flush_waddr",    80'(sram_w_addr), 80'h20);
    chk("flush_init",     80'(init_done),   80'd1);
    @(posedge clock); #1;
    idle();
    #1;
    chk("flush_rvalid", 80'(rd_resp_valid), 80'd1);
    chk("flush_rdata",  rd_resp_data,       P);
    clear_check(256, 0, 100);
    chk("init_after_flush", 80'(init_done), 80'd1);

    // reset while a read response is being presented
    rd_valid = 1'b1; rd_addr = 8'h07;
    @(posedge clock); #1;
    idle();
    chk("pre_rst_rvalid", 80'(rd_resp_valid), 80'd1);
    reset = 1'b0; #1;
    chk("mid_rst_rvalid", 80'(rd_resp_valid), 80'd0);
    chk("mid_rst_rdata",  rd_resp_data,       Z);
    chk("mid_rst_init",   80'(init_done),     80'd0);
    @(negedge clock); reset = 1'b1; #1;

    // reset at clear pointer 100, clearing must restart at set 0
    clear_check(100, 0, 999);
    reset = 1'b0; #1;
    chk("clr_rst_init", 80'(init_done), 80'd0);
    chk("clr_rst_rdy",  80'({rd_ready, wa_ready, wb_ready}), 80'd0);
    @(negedge clock); reset = 1'b1; #1;
    clear_check(256, 0, 999);
    chk("init_after_rst2", 80'(init_done), 80'd1);
    wa_valid = 1'b1; wb_valid = 1'b1; #1;
    chk("prio_after_rst", 80'({wa_ready, wb_ready}), 80'b10);

`ifdef SRAM_WAY_CTRL_PERF_EN
    repeat (70000) @(posedge clock);
    #1;
    chk("perf_conflicts_sat", 80'(perf_conflicts), 80'hFFFF);
`endif
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
